// File: rtl/acc_i8_en_b.sv
// rtl/acc_i8_en_b.sv - enabled sample accumulator: sums LEN enabled samples, publishes y with a valid pulse
module acc_i8_en_b #(
  parameter int               WIDTH = 8,
  parameter int               LEN   = 4,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic             en,
  input  logic             start,
  output logic [WIDTH-1:0] y,
  output logic             valid,
  output logic             busy
);

  localparam int            CW   = $clog2(LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      y     <= INIT;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= ACC;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        ACC: begin
          // a is only read under en so an undriven bus never reaches acc or y
          if (en) begin
            if (cnt == LAST) begin
              y     <= acc + a;
              valid <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end else begin
              acc <= acc + a;
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (start) begin
            state <= ACC;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_i8_en_b.sv
// tb/tb_acc_i8_en_b.sv - self-checking bench for acc_i8_en_b (LEN=4 and LEN=1 instances)
module tb_acc_i8_en_b;

  logic       clock;
  logic       reset;
  logic [7:0] a4, a1;
  logic       en4, en1, start4, start1;
  logic [7:0] y4, y1;
  logic       valid4, valid1, busy4, busy1;

  int checks   = 0;
  int failures = 0;

  acc_i8_en_b #(.WIDTH(8), .LEN(4), .INIT(8'd0)) dut4 (
    .clock(clock), .reset(reset), .a(a4), .en(en4), .start(start4),
    .y(y4), .valid(valid4), .busy(busy4)
  );

  acc_i8_en_b #(.WIDTH(8), .LEN(1), .INIT(8'd0)) dut1 (
    .clock(clock), .reset(reset), .a(a1), .en(en1), .start(start1),
    .y(y1), .valid(valid1), .busy(busy1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       st;
    logic       e;
    logic [7:0] av;
    logic [7:0] ey;
    logic       ev;
    logic       eb;
  } vec_t;

  vec_t       vt[$];
  logic [7:0] sb_q[$];

  // reference model of the LEN=4 instance, advanced whenever stimulus is driven
  int         mst = 0;
  logic [7:0] msum;
  int         mcnt;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic st, input logic e, input logic [7:0] av);
    start4 = st;
    en4    = e;
    a4     = av;
    case (mst)
      1: begin
        if (e) begin
          if (mcnt == 3) begin
            sb_q.push_back(msum + av);
            mst = 2;
          end else begin
            msum = msum + av;
            mcnt++;
          end
        end
      end
      default: begin
        if (st) begin
          mst  = 1;
          msum = 8'd0;
          mcnt = 0;
        end else begin
          mst = 0;
        end
      end
    endcase
  endtask

  task automatic chk4(input string tag, input logic [7:0] ey, input logic ev, input logic eb);
    chk({tag, ".y"}, y4, ey);
    chk({tag, ".valid"}, {7'd0, valid4}, {7'd0, ev});
    chk({tag, ".busy"}, {7'd0, busy4}, {7'd0, eb});
  endtask

  // scoreboard: every valid pulse must match the oldest expected sum
  always begin
    @(posedge clock);
    #1;
    if (valid4 === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_valid: got y=%0d expected no valid at %0t", y4, $time);
      end else begin
        logic [7:0] ex;
        ex = sb_q.pop_front();
        if (y4 !== ex) begin
          failures++;
          $display("FAIL sb_sum: got %0d expected %0d at %0t", y4, ex, $time);
        end
      end
    end
  end

  initial begin
    reset  = 1'b1;
    start4 = 1'b0; en4 = 1'b0; a4 = 8'd0;
    start1 = 1'b0; en1 = 1'b0; a1 = 8'd0;
    #12;
    chk4("rst", 8'd0, 1'b0, 1'b0);
    reset = 1'b0;

    // test 1: idle after reset
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, 8'd0);
      tick();
      chk4("idle", 8'd0, 1'b0, 1'b0);
      chk("idle1.y", y1, 8'd0);
    end

    // tests 2-4 as per-cycle vectors: inputs before the edge, outputs after it
    vt.push_back('{1'b1, 1'b0, 8'd0,   8'd0,  1'b0, 1'b1});
    vt.push_back('{1'b0, 1'b1, 8'd1,   8'd0,  1'b0, 1'b1});
    vt.push_back('{1'b0, 1'b1, 8'd2,   8'd0,  1'b0, 1'b1});
    vt.push_back('{1'b0, 1'b1, 8'd3,   8'd0,  1'b0, 1'b1});
    vt.push_back('{1'b0, 1'b1, 8'd4,   8'd10, 1'b1, 1'b0});
    vt.push_back('{1'b0, 1'b0, 8'd0,   8'd10, 1'b0, 1'b0});
    vt.push_back('{1'b1, 1'b1, 8'd77,  8'd10, 1'b0, 1'b1});
    vt.push_back('{1'b0, 1'b1, 8'd9,   8'd10, 1'b0, 1'b1});
    vt.push_back('{1'b0, 1'b0, 8'd55,  8'd10, 1'b0, 1'b1});
    vt.push_back('{1'b0, 1'b0, 8'd55,  8'd10, 1'b0, 1'b1});
    vt.push_back('{1'b0, 1'b0, 8'd55,  8'd10, 1'b0, 1'b1});
    vt.push_back('{1'b0, 1'b1, 8'd9,   8'd10, 1'b0, 1'b1});
    vt.push_back('{1'b0, 1'b1, 8'd9,   8'd10, 1'b0, 1'b1});
    vt.push_back('{1'b0, 1'b1, 8'd9,   8'd36, 1'b1, 1'b0});
    vt.push_back('{1'b0, 1'b0, 8'd0,   8'd36, 1'b0, 1'b0});
    vt.push_back('{1'b1, 1'b0, 8'd0,   8'd36, 1'b0, 1'b1});
    vt.push_back('{1'b0, 1'b1, 8'd200, 8'd36, 1'b0, 1'b1});
    vt.push_back('{1'b0, 1'b1, 8'd100, 8'd36, 1'b0, 1'b1});
    vt.push_back('{1'b0, 1'b1, 8'd0,   8'd36, 1'b0, 1'b1});
    vt.push_back('{1'b0, 1'b1, 8'd0,   8'd44, 1'b1, 1'b0});
    vt.push_back('{1'b1, 1'b1, 8'd77,  8'd44, 1'b0, 1'b1});
    vt.push_back('{1'b0, 1'b1, 8'd3,   8'd44, 1'b0, 1'b1});
    vt.push_back('{1'b1, 1'b1, 8'd3,   8'd44, 1'b0, 1'b1});
    vt.push_back('{1'b0, 1'b1, 8'd3,   8'd44, 1'b0, 1'b1});
    vt.push_back('{1'b0, 1'b1, 8'd3,   8'd12, 1'b1, 1'b0});
    vt.push_back('{1'b0, 1'b0, 8'd0,   8'd12, 1'b0, 1'b0});
    vt.push_back('{1'b0, 1'b0, 8'd0,   8'd12, 1'b0, 1'b0});

    foreach (vt[i]) begin
      drive(vt[i].st, vt[i].e, vt[i].av);
      tick();
      chk4($sformatf("vec%0d", i), vt[i].ey, vt[i].ev, vt[i].eb);
    end

    // test 5: asynchronous reset after two of four samples
    drive(1'b1, 1'b0, 8'd0); tick();
    drive(1'b0, 1'b1, 8'd1); tick();
    drive(1'b0, 1'b1, 8'd1); tick();
    chk4("pre_rst", 8'd12, 1'b0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk4("async_rst", 8'd0, 1'b0, 1'b0);
    mst = 0;
    tick();
    chk4("hold_rst", 8'd0, 1'b0, 1'b0);
    reset = 1'b0;
    drive(1'b0, 1'b1, 8'd1); tick();
    chk4("post_rst_no_start", 8'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'd0); tick();
    drive(1'b0, 1'b0, 8'bx); tick();
    chk4("x_hold", 8'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 8'd1);
      tick();
    end
    chk4("fresh_sum", 8'd4, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 8'd0); tick();
    chk4("fresh_after", 8'd4, 1'b0, 1'b0);

    // test 6: LEN=1 instance
    start1 = 1'b1; tick();
    chk("len1.busy", {7'd0, busy1}, 8'd1);
    start1 = 1'b0; en1 = 1'b1; a1 = 8'd9; tick();
    chk("len1.y", y1, 8'd9);
    chk("len1.valid", {7'd0, valid1}, 8'd1);
    chk("len1.busy_done", {7'd0, busy1}, 8'd0);
    a1 = 8'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("len1.y_hold", y1, 8'd9);
      chk("len1.valid_low", {7'd0, valid1}, 8'd0);
      chk("len1.busy_low", {7'd0, busy1}, 8'd0);
    end
    en1 = 1'b0;

    tick();
    chk("sb_empty", sb_q.size()[7:0], 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
